// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with optional even parity
// Bits advance only on tick; one IDLE cycle separates consecutive frames.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             tick,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             accept;
    logic             last_data;

    assign accept    = din_valid && (state == IDLE);
    assign last_data = (cnt == LAST_IDX);

    // The output end of the shift register is always the bit currently on ser_out.
    assign sreg_shifted = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && last_data) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : IDLE;
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (accept) begin
            sreg <= din;
            cnt  <= '0;
            par  <= ^din;
        end else if ((state == SHIFT) && tick) begin
            sreg <= sreg_shifted;
            cnt  <= cnt + 1'b1;
        end
    end

    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b1;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
            end
            SHIFT: begin
                ser_out   = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
                ser_valid = 1'b1;
                ser_last  = last_data && (PARITY_EN == 0);
            end
            PARITY: begin
                ser_out   = par;
                ser_valid = 1'b1;
                ser_last  = 1'b1;
            end
            default: begin
                din_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
// Unit 0: MSB first with parity, unit 1: LSB first with parity, unit 2: MSB first without parity.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [7:0] din;
    logic [2:0] dv;
    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] sv;
    logic [2:0] sl;
    logic [2:0] bsy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(dv[0]), .din_ready(rdy[0]),
        .tick(tick), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bsy[0])
    );

    piso_serializer #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(dv[1]), .din_ready(rdy[1]),
        .tick(tick), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bsy[1])
    );

    piso_serializer #(.WIDTH(8), .PARITY_EN(0), .MSB_FIRST(1)) dut_nopar (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(dv[2]), .din_ready(rdy[2]),
        .tick(tick), .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .busy(bsy[2])
    );

    function automatic int pick_need(input int gap);
        if (gap == 0) return 1;
        if (gap > 0) return gap;
        return int'($urandom_range(1, 4));
    endfunction

    // Sends one word on unit u and follows the expected bit list; gap<0 means random tick spacing.
    task automatic run_frame(input int u, input logic [7:0] w, input int gap, input bit hold,
                             input string tag);
        bit exp_bits[$];
        int idx;
        int held;
        int need;
        int cyc;
        for (int i = 0; i < 8; i++) exp_bits.push_back((u != 1) ? w[7-i] : w[i]);
        if (u != 2) exp_bits.push_back(^w);
        din   = w;
        dv[u] = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) dv[u] = 1'b0;
        din  = 8'($urandom);
        idx  = 0;
        held = 0;
        cyc  = 0;
        need = pick_need(gap);
        while (idx < exp_bits.size() && cyc < 100) begin
            tick = (held == need - 1);
            @(negedge clk);
            n_checks++;
            if (sv[u] !== 1'b1 || so[u] !== exp_bits[idx] ||
                sl[u] !== (idx == exp_bits.size() - 1) || rdy[u] !== 1'b0 || bsy[u] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s bit %0d cycle %0d: valid=%b out=%b last=%b ready=%b busy=%b, required 1 %b %b 0 1",
                         tag, idx, held, sv[u], so[u], sl[u], rdy[u], bsy[u], exp_bits[idx],
                         (idx == exp_bits.size() - 1));
            end
            @(posedge clk);
            #1;
            cyc++;
            if (tick) begin
                idx++;
                held = 0;
                need = pick_need(gap);
            end else begin
                held++;
            end
        end
        n_checks++;
        if (idx != exp_bits.size()) begin
            n_fail++;
            $display("FAIL %s timeout: consumed %0d bits, required %0d", tag, idx, exp_bits.size());
        end
        tick = 1'($urandom);
        @(negedge clk);
        n_checks++;
        if (sv[u] !== 1'b0 || so[u] !== 1'b0 || sl[u] !== 1'b0 || rdy[u] !== 1'b1 || bsy[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle gap: valid=%b out=%b last=%b ready=%b busy=%b, required 0 0 0 1 0",
                     tag, sv[u], so[u], sl[u], rdy[u], bsy[u]);
        end
        dv[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dv      = 3'b000;
        tick    = 1'b0;
        din     = 8'h00;
        #12;
        n_checks++;
        if ({rdy, bsy, sv, so, sl} !== {3'b111, 12'b0}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b busy=%b valid=%b out=%b last=%b, required 111 000 000 000 000",
                     rdy, bsy, sv, so, sl);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_msb_parity();
        run_frame(0, 8'hA5, 0, 1'b0, "msb_a5");
    endtask

    task automatic test_lsb_first();
        run_frame(1, 8'h07, 0, 1'b0, "lsb_07");
    endtask

    task automatic test_tick_gaps();
        run_frame(0, 8'hFF, 3, 1'b0, "gap3_ff");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 8'h3C, 0, 1'b1, "b2b_3c");
        run_frame(0, 8'hC3, 0, 1'b1, "b2b_c3");
    endtask

    task automatic test_no_parity();
        run_frame(2, 8'h80, 0, 1'b0, "nopar_80");
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        w     = 8'h5A;
        din   = w;
        dv[0] = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (sv[0] !== 1'b1 || so[0] !== w[3]) begin
            n_fail++;
            $display("FAIL mid_reset bit4: valid=%b out=%b, required 1 %b", sv[0], so[0], w[3]);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sv[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || so[0] !== 1'b0 || sl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset async: valid=%b ready=%b busy=%b out=%b last=%b, required 0 1 0 0 0",
                     sv[0], rdy[0], bsy[0], so[0], sl[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (sv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset no_resume: valid=%b ready=%b, required 0 1", sv[0], rdy[0]);
        end
        run_frame(0, 8'h81, 0, 1'b0, "post_reset_81");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int         u;
            int         gap;
            logic [7:0] w;
            u   = int'($urandom_range(0, 2));
            w   = 8'($urandom);
            gap = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 3));
            run_frame(u, w, gap, 1'($urandom), $sformatf("rand%0d_u%0d_%02h", k, u, w));
        end
    endtask

    initial begin
        test_reset();
        test_msb_parity();
        test_lsb_first();
        test_tick_gaps();
        test_back_to_back();
        test_no_parity();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter PARITY_EN, default 1; 1 appends an even-parity bit after the data bits.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 transmits din[WIDTH-1] first, 0 transmits din[0] first.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  WIDTH  parallel word to transmit.
REQ-007 din_valid  input  1  din holds a word to transmit.
REQ-008 din_ready  output  1  block can accept a word this cycle.
REQ-009 tick  input  1  bit-advance enable; the current serial bit is consumed on any rising edge where tick=1.
REQ-010 ser_out  output  1  current serial bit, registered.
REQ-011 ser_valid  output  1  ser_out carries a frame bit.
REQ-012 ser_last  output  1  ser_out is the final bit of the frame.
REQ-013 busy  output  1  a frame is in progress.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and PARITY.
REQ-015 din_ready SHALL equal 1 exactly when state=IDLE, decoded from the state register only.
REQ-016 Accept SHALL occur on the rising edge where din_valid=1 and din_ready=1: load shift register with din, clear bit counter, compute parity=XOR(din), and enter SHIFT.
REQ-017 din_valid SHALL be ignored outside IDLE; din is sampled only at accept.
REQ-018 The first data bit SHALL appear on ser_out with ser_valid=1 in the cycle after accept.
REQ-019 In SHIFT, each edge with tick=1 SHALL advance one bit (shift toward the output end, counter+1); tick=0 SHALL hold ser_out, counter and state.
REQ-020 In SHIFT with counter=WIDTH-1 and tick=1, the next state SHALL be PARITY if PARITY_EN=1, else IDLE.
REQ-021 In PARITY, ser_out SHALL equal the stored parity bit, so the data bits plus the parity bit contain an even number of ones; tick=1 returns the FSM to IDLE.
REQ-022 ser_last SHALL be 1 on the final frame bit: the parity bit if PARITY_EN=1, else data bit WIDTH-1; otherwise ser_last SHALL be 0.
REQ-023 In IDLE, ser_valid, ser_last and ser_out SHALL be 0, and tick SHALL be ignored.
REQ-024 busy SHALL equal NOT din_ready.
REQ-025 Back-to-back frames SHALL have exactly one IDLE cycle between the final-bit consume edge and the next accept edge; no bit is dropped or duplicated.
REQ-026 Frame length SHALL be WIDTH+PARITY_EN tick-qualified bits, independent of tick gaps.

Reset
REQ-027 While reset_n=0, the block SHALL immediately force state=IDLE, counter=0, shift register=0, ser_out=0, ser_valid=0, ser_last=0, busy=0 and din_ready=1, without waiting for a clock edge.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the aborted word SHALL never resume.
REQ-029 The first accept after reset_n rises SHALL be allowed on the first rising edge of clk.

Verification
REQ-030 WIDTH=8, PARITY_EN=1, MSB_FIRST=1, tick=1 constantly, din=8'hA5 accepted at edge 0 -> ser_out 1,0,1,0,0,1,0,1 in cycles 1-8, then parity 0 in cycle 9 with ser_last=1; din_ready=1 in cycle 10.
REQ-031 din=8'h07, MSB_FIRST=0, tick=1 -> ser_out 1,1,1,0,0,0,0,0, then parity 1 with ser_last=1.
REQ-032 din=8'hFF, tick pulsed every 3rd cycle -> each bit held exactly 3 cycles; 9 bits total; ser_valid stays 1 throughout the frame.
REQ-033 din_valid held at 1 with words 8'h3C then 8'hC3 -> two complete frames separated by exactly one cycle with ser_valid=0; din_valid during SHIFT is ignored.
REQ-034 reset_n pulled low during bit 4 of 8'h5A, asynchronously to clk -> ser_valid=0 and din_ready=1 within the same cycle; after release, a new word 8'h81 serializes correctly from bit 0.
REQ-035 PARITY_EN=0, din=8'h80 -> 8 bits with ser_last=1 on bit 7, then IDLE with no parity cycle.
